// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - Hamming SECDED geometry helpers shared by encoder and decoder
package ecc_pkg;

  // Smallest p with 2^p >= data_w + p + 1
  function automatic int calc_par_w(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int k);
    return (k > 0) && ((k & (k - 1)) == 0);
  endfunction

  // Hamming position of data bit i: the i-th non-power-of-two position from 3 up
  function automatic int data_pos(input int i);
    int k;
    int n;
    k = 2;
    n = -1;
    while (n < i) begin
      k++;
      if (!is_pow2(k)) n++;
    end
    return k;
  endfunction

endpackage

// File: rtl/secded_decoder_pipe_if.sv
// rtl/secded_decoder_pipe_if.sv - codeword in / decoded result out stream bundle
interface secded_decoder_pipe_if #(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 6
);
  localparam int CW = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;
  logic [PAR_W-1:0]  out_syndrome;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
  );
endinterface

// File: rtl/ecc_syndrome.sv
// rtl/ecc_syndrome.sv - combinational Hamming syndrome and overall parity of a codeword
module ecc_syndrome #(
  parameter int CW    = 39,
  parameter int PAR_W = 6
) (
  input  logic [CW-1:0]    code_i,
  output logic [PAR_W-1:0] syn_o,
  output logic             par_o
);

  // Syndrome is the XOR of the indices of all set positions; bit 0 is outside Hamming space
  always_comb begin
    syn_o = '0;
    for (int k = 1; k < CW; k++) begin
      if (code_i[k]) syn_o = syn_o ^ PAR_W'(k);
    end
    par_o = ^code_i;
  end

endmodule

// File: rtl/secded_decoder_pipe.sv
// rtl/secded_decoder_pipe.sv - two-stage pipelined SECDED decoder with error counters
module secded_decoder_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PAR_W  = calc_par_w(DATA_W),
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  secded_decoder_pipe_if.slave  bus,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      sec_cnt,
  output logic [CNT_W-1:0]      ded_cnt
);

  localparam int CW = DATA_W + PAR_W + 1;
  localparam int N  = CW - 1;

  logic              v1_q, v2_q;
  logic [CW-1:0]     code1_q;
  logic [PAR_W-1:0]  syn1_q, syn2_q, syn_d;
  logic              par1_q, par_d;
  logic [DATA_W-1:0] data2_q, data_d;
  logic              sec2_q, ded2_q, sec_d, ded_d;
  logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q, sec_cnt_d, ded_cnt_d;
  logic [CW-1:0]     fixed;
  logic [PAR_W:0]    unused_par;
  logic              adv1, adv2, out_hs;

  assign adv2         = !v2_q || bus.out_ready;
  assign adv1         = !v1_q || adv2;
  assign bus.in_ready = adv1;
  assign out_hs       = v2_q && bus.out_ready;

  ecc_syndrome #(.CW(CW), .PAR_W(PAR_W)) u_syndrome (
    .code_i (bus.in_code),
    .syn_o  (syn_d),
    .par_o  (par_d)
  );

  always_comb begin
    sec_d = 1'b0;
    ded_d = 1'b0;
    if (syn1_q == '0) begin
      sec_d = par1_q;
    end else if (par1_q && (int'(syn1_q) <= N)) begin
      sec_d = 1'b1;
    end else begin
      ded_d = 1'b1;
    end
  end

  // A single error at position 0 lands on the overall parity bit and never reaches the payload
  for (genvar gk = 0; gk < CW; gk++) begin : g_fix
    assign fixed[gk] = code1_q[gk] ^ (sec_d && (int'(syn1_q) == gk));
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
    localparam int P = data_pos(gi);
    assign data_d[gi] = fixed[P];
  end

  assign unused_par[0] = fixed[0];
  for (genvar gj = 0; gj < PAR_W; gj++) begin : g_par
    assign unused_par[gj+1] = fixed[1 << gj];
  end

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (clr_cnt) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_hs) begin
      if (sec2_q && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (ded2_q && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      code1_q   <= '0;
      syn1_q    <= '0;
      par1_q    <= 1'b0;
      v2_q      <= 1'b0;
      data2_q   <= '0;
      sec2_q    <= 1'b0;
      ded2_q    <= 1'b0;
      syn2_q    <= '0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      if (adv1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          code1_q <= bus.in_code;
          syn1_q  <= syn_d;
          par1_q  <= par_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          data2_q <= data_d;
          sec2_q  <= sec_d;
          ded2_q  <= ded_d;
          syn2_q  <= syn1_q;
        end
      end
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign bus.out_valid    = v2_q;
  assign bus.out_data     = data2_q;
  assign bus.out_sec      = sec2_q;
  assign bus.out_ded      = ded2_q;
  assign bus.out_syndrome = syn2_q;
  assign sec_cnt          = sec_cnt_q;
  assign ded_cnt          = ded_cnt_q;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// tb/tb_secded_decoder_pipe.sv - directed vector bench for secded_decoder_pipe at 8/32/64 bits
module tb_secded_decoder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_cnt = 1'b0;
  always #5 clk = ~clk;

  secded_decoder_pipe_if #(.DATA_W(8),  .PAR_W(4)) if8 ();
  secded_decoder_pipe_if #(.DATA_W(32), .PAR_W(6)) if32 ();
  secded_decoder_pipe_if #(.DATA_W(64), .PAR_W(7)) if64 ();
  secded_decoder_pipe_if #(.DATA_W(32), .PAR_W(6)) ifc ();

  logic [15:0] sc8, dc8, sc32, dc32, sc64, dc64;
  logic [1:0]  scc, dcc;

  secded_decoder_pipe #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8), .clr_cnt(clr_cnt), .sec_cnt(sc8), .ded_cnt(dc8));
  secded_decoder_pipe #(.DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32), .clr_cnt(clr_cnt), .sec_cnt(sc32), .ded_cnt(dc32));
  secded_decoder_pipe #(.DATA_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(if64), .clr_cnt(clr_cnt), .sec_cnt(sc64), .ded_cnt(dc64));
  secded_decoder_pipe #(.DATA_W(32), .CNT_W(2)) dutc (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .clr_cnt(clr_cnt), .sec_cnt(scc), .ded_cnt(dcc));

  typedef struct {
    logic        vld;
    logic        rdy;
    logic [63:0] data;
    logic        sec;
    logic        ded;
    logic [6:0]  syn;
    logic [15:0] sc;
    logic [15:0] dc;
  } obs_t;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic [71:0] flip;
    logic [63:0] exp_data;
    logic        exp_sec;
    logic        exp_ded;
    int          exp_syn;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  int   exp_sc[4];
  int   exp_dc[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int dw_of(input int id);
    return (id == 0) ? 8 : (id == 2) ? 64 : 32;
  endfunction

  // Reference encoder written from the codeword layout, independent of the RTL package
  function automatic logic [71:0] encode(input int dw, input logic [63:0] d);
    logic [71:0] c;
    logic        b;
    int          p, n, di;
    p  = (dw == 8) ? 4 : (dw == 32) ? 6 : 7;
    n  = dw + p;
    c  = '0;
    di = 0;
    for (int k = 3; k <= n; k++) begin
      if ((k & (k - 1)) != 0) begin
        c[k] = d[di];
        di++;
      end
    end
    for (int j = 0; j < p; j++) begin
      b = 1'b0;
      for (int k = 1; k <= n; k++)
        if (((k >> j) & 1) == 1 && k != (1 << j)) b = b ^ c[k];
      c[1 << j] = b;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [71:0] fb(input int k);
    return 72'(1) << k;
  endfunction

  function automatic vec_t mk(input int id, input logic [63:0] d, input logic [71:0] f,
                              input logic [63:0] ed, input logic es, input logic edd,
                              input int syn);
    vec_t v;
    v.id = id; v.data = d; v.flip = f; v.exp_data = ed;
    v.exp_sec = es; v.exp_ded = edd; v.exp_syn = syn;
    return v;
  endfunction

  task automatic drive(input int id, input logic v, input logic [71:0] code);
    case (id)
      0:       begin if8.in_valid  = v; if8.in_code  = code[12:0]; end
      1:       begin if32.in_valid = v; if32.in_code = code[38:0]; end
      2:       begin if64.in_valid = v; if64.in_code = code[71:0]; end
      default: begin ifc.in_valid  = v; ifc.in_code  = code[38:0]; end
    endcase
  endtask

  function automatic obs_t observe(input int id);
    obs_t o;
    case (id)
      0: begin
        o.vld = if8.out_valid; o.rdy = if8.in_ready; o.data = 64'(if8.out_data);
        o.sec = if8.out_sec; o.ded = if8.out_ded; o.syn = 7'(if8.out_syndrome);
        o.sc = sc8; o.dc = dc8;
      end
      1: begin
        o.vld = if32.out_valid; o.rdy = if32.in_ready; o.data = 64'(if32.out_data);
        o.sec = if32.out_sec; o.ded = if32.out_ded; o.syn = 7'(if32.out_syndrome);
        o.sc = sc32; o.dc = dc32;
      end
      2: begin
        o.vld = if64.out_valid; o.rdy = if64.in_ready; o.data = if64.out_data;
        o.sec = if64.out_sec; o.ded = if64.out_ded; o.syn = if64.out_syndrome;
        o.sc = sc64; o.dc = dc64;
      end
      default: begin
        o.vld = ifc.out_valid; o.rdy = ifc.in_ready; o.data = 64'(ifc.out_data);
        o.sec = ifc.out_sec; o.ded = ifc.out_ded; o.syn = 7'(ifc.out_syndrome);
        o.sc = 16'(scc); o.dc = 16'(dcc);
      end
    endcase
    return o;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      exp_sc[i] = 0;
      exp_dc[i] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t        o, prev;
    logic [31:0] words[6];
    int          sent, rcv, cmax, bad;

    for (int i = 0; i < 4; i++) begin
      drive(i, 1'b0, '0);
    end
    if8.out_ready = 1'b1; if32.out_ready = 1'b1; if64.out_ready = 1'b1; ifc.out_ready = 1'b1;
    clear_model();

    vecs.push_back(mk(1, 64'hDEADBEEF, '0,                   64'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(1, 64'hDEADBEEF, fb(5),                64'hDEADBEEF, 1, 0, 5));
    vecs.push_back(mk(1, 64'hDEADBEEF, fb(0),                64'hDEADBEEF, 1, 0, 0));
    vecs.push_back(mk(1, 64'hDEADBEEF, fb(3) | fb(17),       64'hDEADB6EE, 0, 1, 18));
    vecs.push_back(mk(1, 64'hDEADBEEF, fb(1) | fb(2),        64'hDEADBEEF, 0, 1, 3));
    vecs.push_back(mk(1, 64'hDEADBEEF, fb(38),               64'hDEADBEEF, 1, 0, 38));
    vecs.push_back(mk(1, 64'hDEADBEEF, fb(32) | fb(8) | fb(1), 64'hDEADBEEF, 0, 1, 41));
    vecs.push_back(mk(0, 64'hA5, '0,                         64'hA5, 0, 0, 0));
    vecs.push_back(mk(0, 64'hA5, fb(5),                      64'hA5, 1, 0, 5));
    vecs.push_back(mk(0, 64'hA5, fb(0),                      64'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 64'hA5, fb(3) | fb(5),              64'hA6, 0, 1, 6));
    vecs.push_back(mk(0, 64'hA5, fb(1) | fb(2),              64'hA5, 0, 1, 3));
    vecs.push_back(mk(0, 64'hA5, fb(12),                     64'hA5, 1, 0, 12));
    vecs.push_back(mk(0, 64'hA5, fb(1) | fb(4) | fb(8),      64'hA5, 0, 1, 13));
    vecs.push_back(mk(2, 64'h0123456789ABCDEF, '0,           64'h0123456789ABCDEF, 0, 0, 0));
    vecs.push_back(mk(2, 64'h0123456789ABCDEF, fb(5),        64'h0123456789ABCDEF, 1, 0, 5));
    vecs.push_back(mk(2, 64'h0123456789ABCDEF, fb(0),        64'h0123456789ABCDEF, 1, 0, 0));
    vecs.push_back(mk(2, 64'h0123456789ABCDEF, fb(3) | fb(17), 64'h0123456789ABC5EE, 0, 1, 18));
    vecs.push_back(mk(2, 64'h0123456789ABCDEF, fb(1) | fb(2),  64'h0123456789ABCDEF, 0, 1, 3));
    vecs.push_back(mk(2, 64'h0123456789ABCDEF, fb(71),       64'h0123456789ABCDEF, 1, 0, 71));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(3, 64'h00001234 + 64'(i), fb(9 + i), 64'h00001234 + 64'(i), 1, 0, 9 + i));
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    o = observe(1);
    check("reset out_valid", 64'(o.vld), 0);
    check("reset in_ready", 64'(o.rdy), 1);
    check("reset out_data", o.data, 0);
    check("reset flags", {o.sec, o.ded}, 0);
    check("reset syndrome", 64'(o.syn), 0);
    check("reset counters", {o.sc, o.dc}, 0);

    foreach (vecs[vi]) begin
      vec_t v;
      v = vecs[vi];
      @(posedge clk);
      #1 drive(v.id, 1'b1, encode(dw_of(v.id), v.data) ^ v.flip);
      @(negedge clk);
      o = observe(v.id);
      check($sformatf("v%0d in_ready", vi), 64'(o.rdy), 1);
      @(posedge clk);
      #1 drive(v.id, 1'b0, '0);
      @(negedge clk);
      o = observe(v.id);
      check($sformatf("v%0d early out_valid", vi), 64'(o.vld), 0);
      @(negedge clk);
      o = observe(v.id);
      check($sformatf("v%0d out_valid", vi), 64'(o.vld), 1);
      check($sformatf("v%0d out_data", vi), o.data, v.exp_data);
      check($sformatf("v%0d out_sec", vi), 64'(o.sec), 64'(v.exp_sec));
      check($sformatf("v%0d out_ded", vi), 64'(o.ded), 64'(v.exp_ded));
      check($sformatf("v%0d out_syndrome", vi), 64'(o.syn), 64'(v.exp_syn));
      cmax = (v.id == 3) ? 3 : 65535;
      if (v.exp_sec && exp_sc[v.id] < cmax) exp_sc[v.id]++;
      if (v.exp_ded && exp_dc[v.id] < cmax) exp_dc[v.id]++;
      @(negedge clk);
      o = observe(v.id);
      check($sformatf("v%0d sec_cnt", vi), 64'(o.sc), 64'(exp_sc[v.id]));
      check($sformatf("v%0d ded_cnt", vi), 64'(o.dc), 64'(exp_dc[v.id]));
    end

    // Six-word stream on the 32-bit decoder with the sink stalled for cycles 2..7
    for (int i = 0; i < 6; i++) words[i] = 32'hA0000000 + 32'(i * 17);
    sent = 0;
    rcv  = 0;
    prev = observe(1);
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      @(posedge clk);
      #1;
      if32.out_ready = !(c >= 2 && c <= 7);
      if (sent < 6) drive(1, 1'b1, encode(32, 64'(words[sent])));
      else          drive(1, 1'b0, '0);
      @(negedge clk);
      o = observe(1);
      if (c >= 2 && c <= 7) check($sformatf("stall c%0d in_ready", c), 64'(o.rdy), 0);
      if (c >= 3 && c <= 7) begin
        check($sformatf("stall c%0d out_valid", c), 64'(o.vld), 1);
        check($sformatf("stall c%0d out_data stable", c), o.data, prev.data);
      end
      if (o.vld && if32.out_ready) begin
        check($sformatf("stream word %0d", rcv), o.data, 64'(words[rcv]));
        rcv++;
      end
      if (if32.in_valid && o.rdy) sent++;
      prev = o;
    end
    check("stream words accepted", 64'(sent), 6);
    check("stream words delivered", 64'(rcv), 6);
    @(posedge clk);
    #1 if32.out_ready = 1'b1;
    drive(1, 1'b0, '0);

    // Reset with two words in flight; counters of the 32-bit decoder are nonzero here
    @(negedge clk);
    o = observe(1);
    check("pre-reset sec_cnt", 64'(o.sc), 64'(exp_sc[1]));
    @(posedge clk);
    #1 if32.out_ready = 1'b0;
    drive(1, 1'b1, encode(32, 64'h12345678) ^ fb(7));
    @(posedge clk);
    #1 drive(1, 1'b1, encode(32, 64'h9ABCDEF0));
    @(posedge clk);
    #1 drive(1, 1'b0, '0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    if32.out_ready = 1'b1;
    clear_model();
    @(negedge clk);
    o = observe(1);
    check("post-reset out_valid", 64'(o.vld), 0);
    check("post-reset in_ready", 64'(o.rdy), 1);
    check("post-reset out_data", o.data, 0);
    check("post-reset flags", {o.sec, o.ded}, 0);
    check("post-reset syndrome", 64'(o.syn), 0);
    check("post-reset counters", {o.sc, o.dc}, 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (if32.out_valid) bad++;
    end
    check("discarded words stay gone", 64'(bad), 0);

    // clr_cnt coinciding with a SEC handshake on the 2-bit-counter decoder
    for (int w = 0; w < 2; w++) begin
      @(posedge clk);
      #1 drive(3, 1'b1, encode(32, 64'h0000BEEF) ^ fb(6));
      @(posedge clk);
      #1 drive(3, 1'b0, '0);
      @(posedge clk);
      #1 clr_cnt = (w == 1);
      @(negedge clk);
      o = observe(3);
      check($sformatf("clr w%0d out_sec", w), 64'(o.sec), 1);
      @(posedge clk);
      #1 clr_cnt = 1'b0;
      @(negedge clk);
      o = observe(3);
      check($sformatf("clr w%0d sec_cnt", w), 64'(o.sc), (w == 1) ? 64'd0 : 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
